bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD digits per input word.
REQ-002 SHALL have parameter BIN_W, default 14: output width; must satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  source presents a BCD word.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_bcd  input  4*DIGITS  packed BCD; most significant digit in the top nibble.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  sink accepts the result.
REQ-010 SHALL have port out_bin  output  BIN_W  unsigned binary value of in_bcd.
REQ-011 SHALL have port out_error  output  1  at least one input nibble was > 9.

Function
REQ-012 SHALL implement three states: IDLE, CONV, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, decoded from state; out_valid = 1 only in DONE.
REQ-014 SHALL accept a word on a rising edge with in_valid && in_ready: in_bcd captured into a shift register, accumulator cleared, digit counter cleared, error flag cleared, state -> CONV.
REQ-015 SHALL, on each CONV edge: take the top nibble d of the shift register; set acc = acc*10 + d; shift the register left by 4; increment the counter.
REQ-016 SHALL, when d > 9, set the sticky error flag and accumulate 0 instead of d.
REQ-017 SHALL move to DONE on the edge that processes the DIGITS-th digit, giving exactly DIGITS CONV cycles.
REQ-018 SHALL assert out_valid on the edge following acceptance edge E0 plus DIGITS edges (latency DIGITS cycles), with out_bin and out_error registered.
REQ-019 SHALL force out_bin = 0 whenever out_error = 1.
REQ-020 SHALL hold out_bin and out_error stable in DONE while out_ready = 0, for any number of cycles.
REQ-021 SHALL return to IDLE on a DONE edge with out_ready = 1; out_valid drops after that edge.
REQ-022 SHALL ignore in_valid in CONV and DONE: no capture, and the in-flight word is not corrupted.
REQ-023 SHALL not accept a new word in the cycle the result is consumed: throughput is at most one word per DIGITS+2 cycles.
REQ-024 SHALL use an accumulator of BIN_W bits; no overflow is possible for legal parameters, so no saturation logic is needed.
REQ-025 SHALL keep out_bin and out_error at their last values outside DONE; sinks must qualify them with out_valid.

Reset
REQ-026 SHALL, while rst_n = 0, force state IDLE, accumulator 0, counter 0, shift register 0, out_bin 0, out_error 0, out_valid 0.
REQ-027 SHALL treat in_ready as 1 during reset, but SHALL NOT capture a handshake while rst_n = 0.
REQ-028 SHALL abort any conversion in progress when reset asserts mid-CONV or mid-DONE, with no result emitted; the first edge after release sees IDLE.

Verification
REQ-029 Basic conversion: in_bcd=16'h1234 accepted, out_ready=1 -> out_valid exactly 4 cycles later, out_bin=1234, out_error=0.
REQ-030 Boundary values: 16'h0000 -> 0; 16'h9999 -> 9999; 16'h0009 -> 9; 16'h1000 -> 1000; all with out_error=0.
REQ-031 Invalid digit: 16'h12A4 -> out_error=1, out_bin=0; also 16'hF000 (error in MSD) and 16'h000B (error in LSD) -> out_error=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_bin stays 4321 and in_ready stays 0; release -> one transfer, then IDLE.
REQ-033 Busy rejection: in_valid held high with changing data during CONV -> only the first word is converted; next acceptance occurs only after the DONE handshake.
REQ-034 Reset mid-operation: rst_n pulsed low after 2 CONV cycles -> all outputs 0 immediately, no out_valid; next word 16'h0042 -> 42.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: serial packed-BCD to unsigned binary converter.
// A word handed over on in_valid/in_ready is converted one digit per cycle,
// most significant digit first (acc = acc*10 + d). The result is held with
// out_valid until the sink takes it with out_ready.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   source presents a BCD word
//   in_ready   converter idle and able to take a word
//   in_bcd     packed BCD, most significant digit in the top nibble
//   out_valid  result available
//   out_ready  sink accepts the result
//   out_bin    binary value of the accepted word (0 when out_error is set)
//   out_error  at least one nibble of the word was greater than 9
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_error
);

  localparam int IN_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   sr;
  logic [BIN_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              err;

  logic [3:0]        d;
  logic              d_bad;
  logic [3:0]        d_eff;
  logic [BIN_W-1:0]  acc_nxt;
  logic              err_nxt;
  logic              last;
  logic              accept;

  // Current digit is always the top nibble; the register shifts left.
  assign d       = sr[IN_W-1 -: 4];
  assign d_bad   = (d > 4'd9);
  assign d_eff   = d_bad ? 4'd0 : d;
  // acc*10 as shift-add; width is sized so no overflow is possible.
  assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(d_eff);
  assign err_nxt = err | d_bad;
  assign last    = (cnt == LAST);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_bin   <= '0;
      out_error <= 1'b0;
    end else begin
      if (accept) begin
        sr  <= in_bcd;
        acc <= '0;
        cnt <= '0;
        err <= 1'b0;
      end else if (state == CONV) begin
        sr  <= sr << 4;
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        err <= err_nxt;
        // Result registers only move on the final digit, so they keep the
        // previous result in every other state.
        if (last) begin
          out_bin   <= err_nxt ? '0 : acc_nxt;
          out_error <= err_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] in_bcd;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    out_bin;
  logic                out_error;

  int n_vec;
  int n_err;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_error (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal value by positional weights; any nibble above 9
  // makes the whole word an error with value 0.
  task automatic model(input logic [4*DIGITS-1:0] bcd,
                       output logic [31:0] val, output logic [31:0] e);
    int v;
    int w;
    int nib;
    v = 0;
    w = 1;
    e = 0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'((bcd >> (4 * i)) & 16'hF);
      if (nib > 9) e = 1;
      v = v + nib * w;
      w = w * 10;
    end
    val = (e != 0) ? 32'd0 : 32'(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete transaction: wait idle, hand over the word, measure latency,
  // optionally hold off the sink, then consume and check return to idle.
  task automatic run_word(input logic [4*DIGITS-1:0] bcd, input int hold, input bit busy);
    int k;
    logic [31:0] eb;
    logic [31:0] ee;
    model(bcd, eb, ee);
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_bcd    = bcd;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    if (busy) in_bcd = 16'($urandom);
    else      in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      chk("in_ready_conv", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      k++;
      if (busy) in_bcd = 16'($urandom);
    end
    chk("latency", 32'(k), 32'(DIGITS));
    chk("out_bin", 32'(out_bin), eb);
    chk("out_error", 32'(out_error), ee);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bin", 32'(out_bin), eb);
      chk("hold_error", 32'(out_error), ee);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("kept_bin", 32'(out_bin), eb);
  endtask

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] w;
    w = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) w = (w << 4) | 16'($urandom_range(10, 15));
      else                           w = (w << 4) | 16'($urandom_range(0, 9));
    end
    return w;
  endfunction

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b1;

    // Reset state; a handshake offered during reset must not be captured.
    #1;
    in_valid = 1'b1;
    in_bcd   = 16'h5555;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(in_ready), 32'd1);

    // Directed values.
    run_word(16'h1234, 0, 1'b0);
    run_word(16'h0000, 0, 1'b0);
    run_word(16'h9999, 0, 1'b0);
    run_word(16'h0009, 0, 1'b0);
    run_word(16'h1000, 0, 1'b0);
    run_word(16'h12A4, 0, 1'b0);
    run_word(16'hF000, 0, 1'b0);
    run_word(16'h000B, 0, 1'b0);
    // Backpressure then busy rejection with changing data.
    run_word(16'h4321, 5, 1'b0);
    run_word(16'h8765, 2, 1'b1);

    // Reset in the middle of a conversion: outputs clear, nothing emitted.
    in_bcd   = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_bin", 32'(out_bin), 32'd0);
    chk("midrst_out_error", 32'(out_error), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIGITS + 2; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_word(16'h0042, 0, 1'b0);

    // Randomized words against the reference.
    for (int n = 0; n < 40; n++) begin
      run_word(rand_bcd(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
